config_chain_loader: RTL and testbench

CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

---
 rtl/config_chain_loader.sv | 176 +++++++++++++++++
 tb/tb_config_chain_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/config_chain_loader.sv
// config_chain_loader
//   Streams a host bitstream (WORD_W-bit words, LSB first) into a serial
//   configuration shift chain of CHAIN_LEN bits, then pulses set_in to commit
//   the chain into the configuration registers and pulses done.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start, abort    begin a load (idle only) / cancel a load in progress
//   in_data/in_valid/in_ready  word stream, valid/ready handshake
//   cen, shift_in   chain shift enable and serial data into the chain
//   shift_out       serial data returning from the chain tail
//   set_in          one-cycle commit pulse
//   busy, done      load in progress (SHIFT or SET) / one-cycle completion pulse
//   rb_data/rb_valid  chain readback words (only with CONFIG_READBACK_EN)
//
// Optional feature: define CONFIG_READBACK_EN to collect shift_out into
// WORD_W-bit readback words.
module config_chain_loader #(
  parameter int CHAIN_LEN = 120,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cen,
  output logic              shift_in,
  input  logic              shift_out,
  output logic              set_in,
  output logic              busy,
  output logic              done
`ifdef CONFIG_READBACK_EN
  ,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int BW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, SET, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]     bits_left;   // chain bits not yet shifted out
  logic [WORD_W-1:0] wbuf;
  logic [BW-1:0]     buf_cnt;     // valid bits left in wbuf
  logic [CW-1:0]     pend;        // chain bits not yet accepted from the host
  logic [BW-1:0]     load_n;
  logic [WORD_W-1:0] load_mask;
  logic              accept;

  // Bits still buffered are already accounted for in bits_left.
  assign pend   = bits_left - CW'(buf_cnt);
  assign accept = in_ready && in_valid && !abort;

  always_comb begin
    load_n = '0;
    if (int'(pend) >= WORD_W) load_n = BW'(WORD_W);
    else                      load_n = BW'(pend);
  end

  // Shift by WORD_W yields zero, so a full word gives an all-ones mask.
  assign load_mask = ~({WORD_W{1'b1}} << load_n);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        if (abort)                             state_nxt = IDLE;
        else if (cen && bits_left == CW'(1))   state_nxt = SET;
      end
      SET:   state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready = 1'b0;
    cen      = 1'b0;
    shift_in = 1'b0;
    set_in   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      SHIFT: begin
        busy     = 1'b1;
        // abort freezes the chain in the cycle it is seen
        cen      = (buf_cnt != '0) && !abort;
        shift_in = cen && wbuf[0];
        // a new word may land while the last buffered bit goes out: no bubble
        in_ready = (pend != '0) && (buf_cnt <= BW'(1));
      end
      SET: begin
        busy   = 1'b1;
        set_in = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Bit counter and word buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      bits_left <= '0;
      wbuf      <= '0;
      buf_cnt   <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        bits_left <= CW'(CHAIN_LEN);
        wbuf      <= '0;
        buf_cnt   <= '0;
      end
    end else if (state == SHIFT && !abort) begin
      if (cen) bits_left <= bits_left - CW'(1);
      if (accept) begin
        wbuf    <= in_data & load_mask;
        buf_cnt <= load_n;
      end else if (cen) begin
        wbuf    <= wbuf >> 1;
        buf_cnt <= buf_cnt - BW'(1);
      end
    end
  end

`ifdef CONFIG_READBACK_EN
  logic [WORD_W-1:0] col_q, col_nxt;
  logic [BW-1:0]     col_cnt;

  assign col_nxt = col_q | (WORD_W'(shift_out) << col_cnt);

  // Emit on a full group or on the last chain bit; unused high bits stay 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      col_cnt  <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (state == IDLE && start) begin
        col_q   <= '0;
        col_cnt <= '0;
      end else if (cen) begin
        if (col_cnt == BW'(WORD_W - 1) || bits_left == CW'(1)) begin
          rb_data  <= col_nxt;
          rb_valid <= 1'b1;
          col_q    <= '0;
          col_cnt  <= '0;
        end else begin
          col_q   <= col_nxt;
          col_cnt <= col_cnt + BW'(1);
        end
      end
    end
  end
`else
  logic unused_shift_out;
  assign unused_shift_out = shift_out;
`endif

endmodule

// File: tb/tb_config_chain_loader.sv
module tb_config_chain_loader;
  localparam int CL = 20;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          rst, start, abort, in_valid, shift_out;
  logic [WW-1:0] in_data;
  logic          in_ready, cen, shift_in, set_in, busy, done;
`ifdef CONFIG_READBACK_EN
  logic [WW-1:0] rb_data;
  logic          rb_valid;
  logic [7:0]    rb_data8;
  logic          rb_valid8;
`endif
  logic          start8, in_valid8, abort8, in_ready8, cen8, shift_in8, set8, busy8, done8;
  logic [7:0]    in_data8;

  int n_chk = 0, n_err = 0, cyc = 0;

  always #5 clk = ~clk;
  assign shift_out = shift_in;   // chain modelled as a loopback wire
  assign abort8    = 1'b0;

  config_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cen(cen), .shift_in(shift_in), .shift_out(shift_out),
    .set_in(set_in), .busy(busy), .done(done)
`ifdef CONFIG_READBACK_EN
    , .rb_data(rb_data), .rb_valid(rb_valid)
`endif
  );

  config_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .abort(abort8),
    .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .cen(cen8), .shift_in(shift_in8), .shift_out(shift_in8),
    .set_in(set8), .busy(busy8), .done(done8)
`ifdef CONFIG_READBACK_EN
    , .rb_data(rb_data8), .rb_valid(rb_valid8)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Event log of the 20-bit instance
  int         cen_cyc[$], set_cyc[$], done_cyc[$];
  logic       cen_bit[$];
  logic [7:0] rb_q[$];
  int         acc_n = 0;
  always @(negedge clk) begin
    if (cen) begin cen_cyc.push_back(cyc); cen_bit.push_back(shift_in); end
    if (set_in) set_cyc.push_back(cyc);
    if (done) done_cyc.push_back(cyc);
    if (in_valid && in_ready) acc_n <= acc_n + 1;
`ifdef CONFIG_READBACK_EN
    if (rb_valid) rb_q.push_back(rb_data);
`endif
  end

  // Event log of the 8-bit instance
  int cen8_n = 0, ones8 = 0, last_cen8 = 0, set8_n = 0, set8_cyc = 0, done8_n = 0;
  logic [7:0] rb8_last = 8'h00;
  always @(negedge clk) begin
    if (cen8) begin
      cen8_n    <= cen8_n + 1;
      ones8     <= ones8 + int'(shift_in8);
      last_cen8 <= cyc;
    end
    if (set8) begin set8_n <= set8_n + 1; set8_cyc <= cyc; end
    if (done8) done8_n <= done8_n + 1;
`ifdef CONFIG_READBACK_EN
    if (rb_valid8) rb8_last <= rb_data8;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one load. gap[i] = cycles in_valid stays low after word i is taken.
  // abort_at>0 aborts once that many bits have shifted; poke pulses start
  // while busy and again in the done cycle.
  task automatic run_load(input logic [7:0] w[$], input int gap[$],
                          input int abort_at, input bit poke);
    int  k, idle, t0, nw, tot, cb, sb, db, ab, rbb, ac, last, idx;
    int  nb[$];
    bit  acc, fin;
    nw = w.size(); tot = 0;
    for (int i = 0; i < nw; i++) begin
      nb.push_back((CL - tot) < WW ? (CL - tot) : WW);
      tot += nb[i];
    end
    cb = cen_cyc.size(); sb = set_cyc.size(); db = done_cyc.size();
    ab = acc_n; rbb = rb_q.size();
    @(posedge clk); #1; start = 1'b1; t0 = cyc;
    @(posedge clk); #1; start = 1'b0; in_valid = 1'b1; in_data = w[0];
    k = 0; idle = 0; fin = 0;
    for (int c = 0; c < 600 && !fin; c++) begin
      start = (poke && c == 3);
      if (abort_at > 0 && cen_cyc.size() - cb >= abort_at) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0; start = 1'b0; fin = 1;
      end else if (done) begin
        start = poke;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0; fin = 1;
        if (poke) chk("start_on_done_busy", 32'(busy), 0);
      end else begin
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        if (acc) begin k++; idle = gap[k-1]; end
        else if (idle > 0) idle--;
        // after the last word keep offering junk: it must be refused
        in_valid = (k >= nw) || (idle == 0);
        in_data  = (k < nw) ? w[k] : 8'($urandom);
      end
    end
    chk("load_terminated", 32'(fin), 1);
    if (abort_at == 0) begin
      chk("cen_count", cen_cyc.size() - cb, CL);
      ac = t0 + 1; idx = cb; last = 0;
      for (int i = 0; i < nw; i++) begin
        for (int b = 0; b < nb[i]; b++) begin
          if (idx < cen_cyc.size()) begin
            chk("cen_cycle", cen_cyc[idx] - t0, ac + 1 + b - t0);
            chk("shift_bit", 32'(cen_bit[idx]), 32'(w[i][b]));
          end
          idx++;
        end
        last = ac + nb[i];
        ac   = (ac + nb[i] > ac + 1 + gap[i]) ? ac + nb[i] : ac + 1 + gap[i];
      end
      chk("set_count", set_cyc.size() - sb, 1);
      if (set_cyc.size() > sb) chk("set_cycle", set_cyc[sb] - t0, last + 1 - t0);
      chk("done_count", done_cyc.size() - db, 1);
      if (done_cyc.size() > db) chk("done_cycle", done_cyc[db] - t0, last + 2 - t0);
      chk("accept_count", acc_n - ab, nw);
`ifdef CONFIG_READBACK_EN
      chk("rb_count", rb_q.size() - rbb, nw);
      for (int i = 0; i < nw && rbb + i < rb_q.size(); i++)
        chk("rb_data", 32'(rb_q[rbb+i]), 32'(w[i] & 8'((1 << nb[i]) - 1)));
`endif
    end
  endtask

  initial begin
    logic [7:0]  w[$];
    int          g[$];
    logic [31:0] seq;
    int          t8, sb, db;

    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    start8 = 1'b0; in_valid8 = 1'b0; in_data8 = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_cen", 32'(cen), 0);
    chk("rst_shift_in", 32'(shift_in), 0);
    chk("rst_set_in", 32'(set_in), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy8", 32'(busy8), 0);
`ifdef CONFIG_READBACK_EN
    chk("rst_rb_valid", 32'(rb_valid), 0);
`endif
    rst = 1'b0;

    // Back-to-back words
    w = '{8'hA5, 8'h3C, 8'h0F}; g = '{0, 0, 0};
    run_load(w, g, 0, 0);
    seq = '0;
    for (int i = 0; i < 20 && i < cen_bit.size(); i++) seq[i] = cen_bit[i];
    chk("spec_sequence", seq, 32'h000F3CA5);

    // Stalls between words
    g = '{5, 5, 0};
    run_load(w, g, 0, 0);

    // Random words and stalls; start poked while busy and on done
    for (int r = 0; r < 4; r++) begin
      w.delete(); g.delete();
      for (int i = 0; i < 3; i++) begin
        w.push_back(8'($urandom));
        g.push_back(int'($urandom_range(0, 9)));
      end
      run_load(w, g, 0, (r == 1));
    end

    // Abort after 9 bits, then a clean reload
    sb = set_cyc.size(); db = done_cyc.size();
    run_load(w, g, 9, 0);
    chk("abort_busy", 32'(busy), 0);
    repeat (4) @(posedge clk); #1;
    chk("abort_no_set", set_cyc.size() - sb, 0);
    chk("abort_no_done", done_cyc.size() - db, 0);
    g = '{0, 0, 0};
    run_load(w, g, 0, 0);

    // Reset in the middle of a load wins over start and data
    sb = set_cyc.size();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
    repeat (5) @(posedge clk); #1;
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_cen", 32'(cen), 0);
    chk("mid_rst_shift_in", 32'(shift_in), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("mid_rst_no_set", set_cyc.size() - sb, 0);
    chk("mid_rst_idle", 32'(busy), 0);

    // Single full word on an 8-bit chain
    @(posedge clk); #1; start8 = 1'b1; t8 = cyc;
    @(posedge clk); #1; start8 = 1'b0; in_valid8 = 1'b1; in_data8 = 8'hFF;
    chk("w8_ready_first", 32'(in_ready8), 1);
    @(posedge clk); #1;
    chk("w8_ready_after", 32'(in_ready8), 0);
    repeat (12) @(posedge clk); #1;
    in_valid8 = 1'b0;
    chk("w8_cen_count", cen8_n, 8);
    chk("w8_ones", ones8, 8);
    chk("w8_last_cen", last_cen8 - t8, 9);
    chk("w8_set_count", set8_n, 1);
    chk("w8_set_cycle", set8_cyc - t8, 10);
    chk("w8_done_count", done8_n, 1);
`ifdef CONFIG_READBACK_EN
    chk("w8_rb", 32'(rb8_last), 32'hFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
